// File: rtl/display_scanout.sv
// Read side of the frame path: fetches one stored line per active line and
// serialises it into pixels with programmable horizontal/vertical blanking.
module display_scanout #(
   parameter int PIX_W   = 24,
   parameter int MAX_PIX = 110,
   parameter int CNT_W   = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic [CNT_W-1:0]             HBOut_PD,
   input  logic [CNT_W-1:0]             VBOut_PD,
   input  logic [CNT_W-1:0]             AIPOut_PD,
   input  logic [CNT_W-1:0]             AILOut_PD,
   output logic                         LineReq,
   output logic [CNT_W-1:0]             LineIndex,
   input  logic                         LineValid,
   input  logic [0:PIX_W*MAX_PIX-1]     LineData,
   output logic [PIX_W-1:0]             Pixel,
   output logic                         HSync,
   output logic                         VSync,
   output logic                         DataEn,
   output logic                         FrameDone,
   output logic                         Underflow
);
   localparam int LINE_W = PIX_W * MAX_PIX;
   localparam int HW     = CNT_W + 1;
   localparam int BW     = $clog2(LINE_W);

   typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;

   state_t             state_q, state_d;
   logic [HW-1:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [CNT_W-1:0]   hb_q, hb_d, vb_q, vb_d, aip_q, aip_d, ail_q, ail_d;
   logic [0:LINE_W-1]  line_q, line_d;
   logic               got_q, got_d, win_q, win_d, win_last_q, win_last_d;
   logic [PIX_W-1:0]   pixel_q, pixel_d;
   logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic               fd_q, fd_d, lreq_q, lreq_d, uf_q, uf_d;
   logic [CNT_W-1:0]   idx_q, idx_d;

   logic [CNT_W-1:0]   hb_in, aip_in;
   logic               cfg_ok, start, line_end, last_line, cap;
   logic [HW-1:0]      line_len, frame_len, hn, vn, k;
   logic [BW-1:0]      pix_base;
   logic [0:LINE_W-1]  src;

   // Sanitised config as it would be latched this cycle
   always_comb begin
      hb_in  = (HBOut_PD < CNT_W'(2)) ? CNT_W'(2) : HBOut_PD;
      aip_in = (AIPOut_PD > CNT_W'(MAX_PIX)) ? CNT_W'(MAX_PIX) : AIPOut_PD;
      cfg_ok = run && (AIPOut_PD != '0) && (AILOut_PD != '0);
   end

   assign line_len  = HW'(hb_q) + HW'(aip_q);
   assign frame_len = HW'(vb_q) + HW'(ail_q);
   assign line_end  = (hcnt_q == line_len - HW'(1));
   assign last_line = (vcnt_q == frame_len - HW'(1));

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      hb_d    = hb_q;
      vb_d    = vb_q;
      aip_d   = aip_q;
      ail_d   = ail_q;
      start   = 1'b0;
      hn      = line_end ? '0 : hcnt_q + HW'(1);
      vn      = line_end ? vcnt_q + HW'(1) : vcnt_q;
      if (state_q == IDLE) begin
         start = cfg_ok;
      end else if (line_end && last_line) begin
         start = cfg_ok;
         if (!cfg_ok) begin
            state_d = IDLE;
            hcnt_d  = '0;
            vcnt_d  = '0;
         end
      end else begin
         hcnt_d = hn;
         vcnt_d = vn;
         if (vn < HW'(vb_q))       state_d = VBLANK;
         else if (hn < HW'(hb_q))  state_d = HBLANK;
         else                      state_d = ACTIVE;
      end
      if (start) begin
         hb_d    = hb_in;
         vb_d    = VBOut_PD;
         aip_d   = aip_in;
         ail_d   = AILOut_PD;
         hcnt_d  = '0;
         vcnt_d  = '0;
         state_d = (VBOut_PD != '0) ? VBLANK : HBLANK;
      end
   end

   // Output stage lags the state register by one cycle; the fetch window is
   // tracked on that same delayed timeline so LineReq and capture line up.
   always_comb begin
      k        = hcnt_q - HW'(hb_q);
      pix_base = BW'(k) * BW'(PIX_W);
      cap      = win_q && LineValid && (lreq_q || !got_q);
      src      = cap ? LineData : line_q;
      pixel_d  = (state_q == ACTIVE) ? src[pix_base +: PIX_W] : '0;
      vsync_d  = (state_q == VBLANK);
      hsync_d  = (state_q == HBLANK);
      de_d     = (state_q == ACTIVE);
      lreq_d   = (state_q == HBLANK) && (hcnt_q == '0);
      idx_d    = CNT_W'(vcnt_q - HW'(vb_q));
      fd_d     = (state_q == ACTIVE) && line_end && last_line;
      win_d    = (state_q == HBLANK);
      win_last_d = (state_q == HBLANK) && (hcnt_q == HW'(hb_q) - HW'(1));
      got_d    = got_q;
      line_d   = line_q;
      if (lreq_q) begin
         got_d  = LineValid;
         line_d = LineValid ? LineData : '0;
      end else if (cap) begin
         got_d  = 1'b1;
         line_d = LineData;
      end
      // HB is at least 2, so the last window cycle never coincides with LineReq
      uf_d = uf_q || (win_last_q && !(cap || got_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         hb_q       <= '0;
         vb_q       <= '0;
         aip_q      <= '0;
         ail_q      <= '0;
         got_q      <= 1'b0;
         win_q      <= 1'b0;
         win_last_q <= 1'b0;
         pixel_q    <= '0;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         de_q       <= 1'b0;
         fd_q       <= 1'b0;
         lreq_q     <= 1'b0;
         idx_q      <= '0;
         uf_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         hb_q       <= hb_d;
         vb_q       <= vb_d;
         aip_q      <= aip_d;
         ail_q      <= ail_d;
         got_q      <= got_d;
         win_q      <= win_d;
         win_last_q <= win_last_d;
         pixel_q    <= pixel_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         de_q       <= de_d;
         fd_q       <= fd_d;
         lreq_q     <= lreq_d;
         idx_q      <= idx_d;
         uf_q       <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      line_q <= line_d;
   end

   assign Pixel     = pixel_q;
   assign HSync     = hsync_q;
   assign VSync     = vsync_q;
   assign DataEn    = de_q;
   assign FrameDone = fd_q;
   assign LineReq   = lreq_q;
   assign LineIndex = idx_q;
   assign Underflow = uf_q;
endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout: timing, fetch, underflow, clamping, reset.
module tb_display_scanout;
   localparam int PIX_W = 24, MAX_PIX = 110, CNT_W = 10;
   localparam int LINE_W = PIX_W * MAX_PIX;

   logic clk = 1'b0;
   logic reset, run, LineValid, LineReq, HSync, VSync, DataEn, FrameDone, Underflow;
   logic [CNT_W-1:0] HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD, LineIndex;
   logic [0:LINE_W-1] LineData;
   logic [PIX_W-1:0] Pixel;

   int checks = 0, errors = 0;
   int mode = 1, skip_idx = -1;
   logic pend = 1'b0;
   logic [CNT_W-1:0] pend_idx = '0;
   logic [PIX_W-1:0] last_pix = '0;

   always #5 clk = ~clk;

   display_scanout #(.PIX_W(PIX_W), .MAX_PIX(MAX_PIX), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .run(run),
      .HBOut_PD(HBOut_PD), .VBOut_PD(VBOut_PD), .AIPOut_PD(AIPOut_PD), .AILOut_PD(AILOut_PD),
      .LineReq(LineReq), .LineIndex(LineIndex), .LineValid(LineValid), .LineData(LineData),
      .Pixel(Pixel), .HSync(HSync), .VSync(VSync), .DataEn(DataEn),
      .FrameDone(FrameDone), .Underflow(Underflow)
   );

   function automatic logic [PIX_W-1:0] pat(input int l, input int i);
      return (mode != 0) ? PIX_W'(((l + 1) << 16) | i) : PIX_W'(i);
   endfunction

   function automatic logic [0:LINE_W-1] mk_line(input int l);
      logic [0:LINE_W-1] v;
      v = '0;
      for (int i = 0; i < MAX_PIX; i++) v[PIX_W*i +: PIX_W] = pat(l, i);
      return v;
   endfunction

   function automatic logic [39:0] outs();
      return {Pixel, HSync, VSync, DataEn, FrameDone, LineReq, LineIndex, Underflow};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; answer a LineReq one cycle later unless that line is withheld
   task automatic step();
      @(posedge clk);
      #1;
      LineValid = pend;
      if (pend) LineData = mk_line(int'(pend_idx));
      pend     = LineReq && (skip_idx != int'(LineIndex));
      pend_idx = LineIndex;
   endtask

   // Called with the current sample at output cycle 0 of a frame
   task automatic check_frame(input string tag, input int hb, input int vb, input int aip,
                              input int ail, input int skip);
      int ll, line, h, kk, flen, bv, bh, bd, bp, br, bi, bf, nde, nfd;
      logic ev, eh, ed, er, ef;
      logic [PIX_W-1:0] ep;
      ll = hb + aip; flen = (vb + ail) * ll;
      bv = 0; bh = 0; bd = 0; bp = 0; br = 0; bi = 0; bf = 0; nde = 0; nfd = 0;
      for (int c = 0; c < flen; c++) begin
         line = c / ll; h = c % ll; kk = h - hb;
         ev = (line < vb);
         eh = !ev && (h < hb);
         ed = !ev && (h >= hb);
         er = !ev && (h == 0);
         ef = (c == flen - 1);
         ep = (ed && (line - vb) != skip) ? pat(line - vb, kk) : '0;
         if (VSync !== ev) bv++;
         if (HSync !== eh) bh++;
         if (DataEn !== ed) bd++;
         if (Pixel !== ep) bp++;
         if (LineReq !== er) br++;
         if (er && LineIndex !== CNT_W'(line - vb)) bi++;
         if (FrameDone !== ef) bf++;
         if (DataEn === 1'b1) nde++;
         if (FrameDone === 1'b1) nfd++;
         if (ed && kk == aip - 1) last_pix = Pixel;
         step();
      end
      chk({tag, " vsync_bad"}, bv, 0);
      chk({tag, " hsync_bad"}, bh, 0);
      chk({tag, " dataen_bad"}, bd, 0);
      chk({tag, " pixel_bad"}, bp, 0);
      chk({tag, " linereq_bad"}, br, 0);
      chk({tag, " lineindex_bad"}, bi, 0);
      chk({tag, " framedone_bad"}, bf, 0);
      chk({tag, " dataen_count"}, nde, ail * aip);
      chk({tag, " framedone_count"}, nfd, 1);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; LineValid = 1'b0; LineData = '0;
      HBOut_PD = '0; VBOut_PD = '0; AIPOut_PD = '0; AILOut_PD = '0;
      step(); step();
      chk("reset outputs", outs(), 40'd0);

      // Small frame: HB=2 VB=1 AIP=4 AIL=2, 18 cycles
      reset = 1'b0; mode = 1;
      HBOut_PD = 10'd2; VBOut_PD = 10'd1; AIPOut_PD = 10'd4; AILOut_PD = 10'd2;
      run = 1'b1;
      step();
      chk("start latency vsync", VSync, 1'b0);
      step();
      chk("frame1 first vsync", VSync, 1'b1);
      check_frame("frame1", 2, 1, 4, 2, -1);
      chk("frame1 underflow", Underflow, 1'b0);

      // Line 1 withheld; underflow must persist into the following frame
      skip_idx = 1;
      check_frame("uf", 2, 1, 4, 2, 1);
      chk("uf sticky set", Underflow, 1'b1);
      skip_idx = -1;
      check_frame("uf_next", 2, 1, 4, 2, -1);
      chk("uf sticky held", Underflow, 1'b1);

      // run dropped right after the frame starts
      run = 1'b0;
      check_frame("rundrop", 2, 1, 4, 2, -1);
      chk("rundrop idle syncs", {VSync, HSync, DataEn, LineReq}, 4'd0);
      step(); step(); step();
      chk("rundrop still idle", {Pixel, VSync, HSync, DataEn, FrameDone, LineReq}, 29'd0);

      reset = 1'b1; step(); reset = 1'b0;
      chk("reset clears underflow", Underflow, 1'b0);

      // AIL=0 never leaves IDLE
      HBOut_PD = 10'd2; VBOut_PD = 10'd1; AIPOut_PD = 10'd4; AILOut_PD = 10'd0;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ail0 idle outputs", outs(), 40'd0);
      end

      // Reset in the middle of an active line with underflow already set
      AILOut_PD = 10'd2; skip_idx = 0;
      step(); step();
      for (int i = 0; i < 9; i++) step();
      chk("midreset dataen before", DataEn, 1'b1);
      chk("midreset underflow before", Underflow, 1'b1);
      chk("midreset withheld pixel", Pixel, 24'd0);
      reset = 1'b1;
      step();
      chk("midreset outputs", outs(), 40'd0);
      reset = 1'b0; run = 1'b0; skip_idx = -1;
      step();
      chk("midreset idle after", outs(), 40'd0);

      // HB=0 and AIP=120 clamp to HB=2, AIP=110
      mode = 0;
      HBOut_PD = 10'd0; VBOut_PD = 10'd1; AIPOut_PD = 10'd120; AILOut_PD = 10'd2;
      run = 1'b1;
      step(); step();
      run = 1'b0;
      check_frame("clamp", 2, 1, 110, 2, -1);
      chk("clamp last pixel", last_pix, 24'd109);
      chk("clamp idle after", DataEn, 1'b0);

      // Default config, two back-to-back frames
      HBOut_PD = 10'd10; VBOut_PD = 10'd10; AIPOut_PD = 10'd100; AILOut_PD = 10'd100;
      run = 1'b1;
      step(); step();
      check_frame("dflt0", 10, 10, 100, 100, -1);
      check_frame("dflt1", 10, 10, 100, 100, -1);
      chk("dflt underflow", Underflow, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
